regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port, the one driven through the 5-to-32 write-enable decoder, between two writers.
- Writer A is the in-order pipeline writeback and is normally prioritised. Writer B is the long-latency multdiv completion.
- B results go into a small FIFO and drain when the port is free.
- A starvation limit guarantees B progress by stalling A. Newer A writes kill stale queued B writes to the same register.

Parameters:
DEPTH, 4, B FIFO entries (power of 2, >=2)
MAX_WAIT, 3, cycles a non-empty FIFO head may be passed over before it is forced onto the port

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
a_valid  in  1  pipeline writeback request
a_addr  in  5  pipeline destination register
a_data  in  32  pipeline write data
a_stall  out  1  A not granted this cycle; pipeline holds A stable
b_valid  in  1  multdiv result valid
b_addr  in  5  multdiv destination register
b_data  in  32  multdiv result
b_ready  out  1  B accepted when b_valid&&b_ready
ctrl_writeEnable  out  1  register file write enable
ctrl_writeReg  out  5  write address (to decoder)
data_writeReg  out  32  write data
fifo_count  out  log2(DEPTH)+1  queued B entries

Behaviour:
- Reset (sampled at clock edge) clears:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - FIFO emptied; fifo_count=0; starve counter=0.
- b_ready=0 while reset is high, otherwise b_ready=(fifo_count<DEPTH).
- a_stall is combinational. All other outputs are registered.
- Address 0: a request with addr==0 is accepted (no stall, b_ready handshake completes), then discarded. It never reaches the port or the FIFO.
- Grant priority, evaluated each cycle:
  1. force = (FIFO non-empty && starve>=MAX_WAIT). Grant FIFO head. a_stall = a_valid.
  2. Otherwise, if a_valid && a_addr!=0, grant A.
  3. Otherwise, if FIFO non-empty, grant FIFO head (pop).
  4. Otherwise, if b_valid && b_addr!=0, grant B directly (bypass; not pushed).
- Push: an accepted B request that is not directly granted is pushed to the FIFO tail.
- Simultaneous push and pop in the same cycle: fifo_count unchanged.
- Starve counter:
  - Increments when the FIFO is non-empty at cycle start and the head is not granted.
  - Clears on head grant or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- Kill rule:
  - When A is granted to addr X, every FIFO entry with addr X is invalidated.
  - A concurrently accepted B request with addr X is discarded and not pushed.
  - Invalid entries are dropped at the head without using the port. A drop costs no cycle, since the head pointer skips invalid entries combinationally. Killed entries do not count in fifo_count.
- Output latency: a grant in cycle N drives ctrl_writeEnable=1, ctrl_writeReg and data_writeReg in cycle N+1 for exactly one cycle. With no grant, ctrl_writeEnable=0 and addr/data hold their last value.
- Full FIFO with b_valid: b_ready=0, and B holds. A pop in the same cycle does not raise b_ready until the next cycle.
- Reset mid-operation: queued entries are lost. No write-enable pulse occurs in the cycle after reset is sampled.

Optional Feature:
- Macro: REGFILE_WRITE_FWD_EN.
- When defined, add three ports:
  - fwd_addr in 5
  - fwd_hit out 1
  - fwd_data out 32
- Forwarding behaviour (combinational):
  - fwd_hit=1 when fwd_addr!=0 and a valid FIFO entry or the registered output stage (ctrl_writeEnable=1) holds fwd_addr.
  - fwd_data returns the newest match, with priority output stage > FIFO tail > head.
- When undefined, the ports are absent and no comparators are built.

Test Plan:
- B only, FIFO empty: b_valid=1, b_addr=5, b_data=0x1234 at cycle 0 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234; fifo_count stays 0.
- Conflict: A(addr 3, 0xA) and B(addr 7, 0xB) both at cycle 0 -> cycle 1 writes reg 3; fifo_count=1; cycle 2 writes reg 7 (A idle).
- Starvation, MAX_WAIT=3: one B queued, A valid every cycle -> 3 A writes, then a_stall=1 for one cycle and reg B written, then A resumes.
- Kill: B(addr 9, 0x99) queued; A writes addr 9, 0x55 -> only 0x55 reaches reg 9; fifo_count drops to 0; no further write to 9.
- Full/zero: DEPTH=4, A saturated, push 4 B entries -> b_ready=0 on 5th. Separately, A addr 0 -> a_stall=0, ctrl_writeEnable stays 0.
- Reset with 2 entries queued -> next cycle fifo_count=0, ctrl_writeEnable=0. With REGFILE_WRITE_FWD_EN, a queued addr 4 gives fwd_hit=1 and the correct data before reset.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and queued multdiv results (B).
// Define REGFILE_WRITE_FWD_EN to add the fwd_addr/fwd_hit/fwd_data lookup ports.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 3,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1,
    localparam int unsigned ADDR_W  = 5,
    localparam int unsigned DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_stall,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
`ifdef REGFILE_WRITE_FWD_EN
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned STV_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    // FIFO is kept compacted: slot 0 is always the oldest live entry, so killed
    // entries vanish immediately and the head never points at a dead slot.
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              head_valid, force_head;
    logic              a_live, b_accept, b_live;
    logic              grant_a, grant_head, grant_b, push;
    logic [CNT_W-1:0]  fill;

    // Grant selection
    always_comb begin
        head_valid = (count_q != '0);
        force_head = head_valid && (starve_q >= STV_W'(MAX_WAIT));
        a_live     = a_valid && (a_addr != '0);
        b_ready    = !reset && (count_q < CNT_W'(DEPTH));
        b_accept   = b_valid && b_ready;
        b_live     = b_accept && (b_addr != '0);
        grant_a    = !force_head && a_live;
        grant_head = force_head || (!a_live && head_valid);
        grant_b    = !force_head && !a_live && !head_valid && b_live;
        push       = b_live && !grant_b && !(grant_a && (b_addr == a_addr));
        a_stall    = force_head && a_live;
    end

    // Next state: FIFO compaction with kill/pop/push, starve counter, write stage
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fill        = '0;
        starve_d    = '0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && !(grant_head && (i == 0)) &&
                !(grant_a && (fifo_addr_q[i] == a_addr))) begin
                fifo_addr_d[fill[IDX_W-1:0]] = fifo_addr_q[i];
                fifo_data_d[fill[IDX_W-1:0]] = fifo_data_q[i];
                fill = fill + CNT_W'(1);
            end
        end
        if (push) begin
            fifo_addr_d[fill[IDX_W-1:0]] = b_addr;
            fifo_data_d[fill[IDX_W-1:0]] = b_data;
            fill = fill + CNT_W'(1);
        end
        count_d = fill;

        if (head_valid && !grant_head) begin
            starve_d = (starve_q < STV_W'(MAX_WAIT)) ? starve_q + STV_W'(1) : starve_q;
        end

        if (grant_a) begin
            we_d    = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
        end else if (grant_head) begin
            we_d    = 1'b1;
            waddr_d = fifo_addr_q[0];
            wdata_d = fifo_data_q[0];
        end else if (grant_b) begin
            we_d    = 1'b1;
            waddr_d = b_addr;
            wdata_d = b_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = waddr_q;
    assign data_writeReg    = wdata_q;
    assign fifo_count       = count_q;

`ifdef REGFILE_WRITE_FWD_EN
    // Newest match wins: output stage over FIFO, FIFO tail over head
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[i] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[i];
            end
        end
        if (we_q && (waddr_q == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wdata_q;
        end
        if (fwd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule
